exception_ctrl: RTL and testbench

Precise-exception controller for the MEM stage; the writer side of the CP0 register block. It samples exception flags, interrupt lines and ERET from the retiring instruction, and picks one event by fixed priority. It then drives the CP0 hardware write port (per-register write enables plus EPC/BadVAddr/Cause/Status data), flushes the pipeline and redirects fetch. It reads back the Status/Cause/EPC register outputs to decide interrupt eligibility and the ERET target.

---
 rtl/exception_ctrl_if.sv | 40 ++++
 rtl/exception_ctrl.sv | 131 +++++++++++++
 tb/tb_exception_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/exception_ctrl_if.sv
// rtl/exception_ctrl_if.sv - MEM-stage event inputs and CP0 write-port outputs of exception_ctrl
interface exception_ctrl_if #(parameter int WIDTH = 32);
  logic             exc_valid;
  logic [WIDTH-1:0] exc_pc;
  logic             exc_in_delay_slot;
  logic [6:0]       exc_flags;
  logic [WIDTH-1:0] exc_data_addr;
  logic             eret;
  logic [5:0]       hw_int;
  logic [WIDTH-1:0] status_in;
  logic [WIDTH-1:0] cause_in;
  logic [WIDTH-1:0] epc_in;
  logic [WIDTH-1:0] cp0_we;
  logic [WIDTH-1:0] cp0_epc;
  logic [WIDTH-1:0] cp0_badaddr;
  logic [4:0]       cp0_exc_code;
  logic             cp0_branch_delay;
  logic [5:0]       cp0_hw_int;
  logic [7:0]       cp0_int_enable;
  logic             cp0_exl;
  logic             cp0_ie;
  logic             flush;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             busy;

  modport master (
    output exc_valid, exc_pc, exc_in_delay_slot, exc_flags, exc_data_addr, eret,
           hw_int, status_in, cause_in, epc_in,
    input  cp0_we, cp0_epc, cp0_badaddr, cp0_exc_code, cp0_branch_delay, cp0_hw_int,
           cp0_int_enable, cp0_exl, cp0_ie, flush, redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  exc_valid, exc_pc, exc_in_delay_slot, exc_flags, exc_data_addr, eret,
           hw_int, status_in, cause_in, epc_in,
    output cp0_we, cp0_epc, cp0_badaddr, cp0_exc_code, cp0_branch_delay, cp0_hw_int,
           cp0_int_enable, cp0_exl, cp0_ie, flush, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - precise-exception controller: picks one MEM-stage event by priority,
// writes CP0, flushes the pipeline and redirects fetch.
module exception_ctrl #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'hBFC00380)
) (
  input logic             clk,
  input logic             rst,
  exception_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT, ERET_REDIRECT} state_t;

  localparam logic [WIDTH-1:0] WE_EXC  = WIDTH'(32'h0000_7000);
  localparam logic [WIDTH-1:0] WE_ADDR = WIDTH'(32'h0000_0100);
  localparam logic [WIDTH-1:0] WE_ERET = WIDTH'(32'h0000_1000);

  state_t           state;
  logic [5:0]       int_meta;
  logic [5:0]       int_sync;
  logic             int_req;
  logic             sel_take;
  logic [4:0]       sel_code;
  logic [WIDTH-1:0] sel_bad;

  logic [WIDTH-1:0] we_q;
  logic [WIDTH-1:0] epc_q;
  logic [WIDTH-1:0] bad_q;
  logic [4:0]       code_q;
  logic             bd_q;
  logic             exl_q;
  logic             flush_q;
  logic             redir_q;
  logic [WIDTH-1:0] redir_pc_q;

  // EXL (status_in[1]) masks interrupts, so nothing nests on top of a taken exception
  assign int_req = bus.status_in[0] & ~bus.status_in[1] &
                   (|({int_sync, bus.cause_in[9:8]} & bus.status_in[15:8]));

  always_comb begin
    sel_take = 1'b1;
    sel_code = 5'd0;
    sel_bad  = '0;
    if (int_req)                sel_code = 5'd0;
    else if (bus.exc_flags[0])  begin sel_code = 5'd4;  sel_bad = bus.exc_pc;        end
    else if (bus.exc_flags[1])  sel_code = 5'd10;
    else if (bus.exc_flags[2])  sel_code = 5'd12;
    else if (bus.exc_flags[3])  sel_code = 5'd8;
    else if (bus.exc_flags[4])  sel_code = 5'd9;
    else if (bus.exc_flags[5])  begin sel_code = 5'd4;  sel_bad = bus.exc_data_addr; end
    else if (bus.exc_flags[6])  begin sel_code = 5'd5;  sel_bad = bus.exc_data_addr; end
    else                        sel_take = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_meta <= '0;
      int_sync <= '0;
    end else begin
      int_meta <= bus.hw_int;
      int_sync <= int_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= '0;
      epc_q      <= '0;
      bad_q      <= '0;
      code_q     <= '0;
      bd_q       <= 1'b0;
      exl_q      <= 1'b0;
      flush_q    <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.exc_valid && sel_take) begin
            state   <= COMMIT;
            we_q    <= (sel_code == 5'd4 || sel_code == 5'd5) ? (WE_EXC | WE_ADDR) : WE_EXC;
            epc_q   <= bus.exc_in_delay_slot ? bus.exc_pc - WIDTH'(4) : bus.exc_pc;
            bad_q   <= sel_bad;
            code_q  <= sel_code;
            bd_q    <= bus.exc_in_delay_slot;
            exl_q   <= 1'b1;
            flush_q <= 1'b1;
          end else if (bus.exc_valid && bus.eret) begin
            state      <= ERET_REDIRECT;
            we_q       <= WE_ERET;
            exl_q      <= 1'b0;
            flush_q    <= 1'b1;
            redir_q    <= 1'b1;
            redir_pc_q <= bus.epc_in;
          end
        end
        COMMIT: begin
          state      <= REDIRECT;
          we_q       <= '0;
          exl_q      <= 1'b0;
          flush_q    <= 1'b1;
          redir_q    <= 1'b1;
          redir_pc_q <= EXC_VECTOR;
        end
        default: begin
          state      <= IDLE;
          we_q       <= '0;
          exl_q      <= 1'b0;
          flush_q    <= 1'b0;
          redir_q    <= 1'b0;
          redir_pc_q <= '0;
        end
      endcase
    end
  end

  // Status copies track status_in live during the two write states
  assign bus.cp0_ie           = (state == COMMIT || state == ERET_REDIRECT) ? bus.status_in[0] : 1'b0;
  assign bus.cp0_int_enable   = (state == COMMIT || state == ERET_REDIRECT) ? bus.status_in[15:8] : 8'h00;
  assign bus.cp0_we           = we_q;
  assign bus.cp0_epc          = epc_q;
  assign bus.cp0_badaddr      = bad_q;
  assign bus.cp0_exc_code     = code_q;
  assign bus.cp0_branch_delay = bd_q;
  assign bus.cp0_hw_int       = int_sync;
  assign bus.cp0_exl          = exl_q;
  assign bus.flush            = flush_q;
  assign bus.redirect_valid   = redir_q;
  assign bus.redirect_pc      = redir_pc_q;
  assign bus.busy             = (state != IDLE);
endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - directed vector table plus hand sequences for exception_ctrl
module tb_exception_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  exception_ctrl_if #(.WIDTH(32)) bus ();
  exception_ctrl #(.WIDTH(32), .EXC_VECTOR(32'hBFC00380)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        ds;
    logic [6:0]  flags;
    logic [31:0] addr;
    logic        er;
    logic [31:0] status;
    logic        take;
    logic [4:0]  code;
    logic [31:0] we;
    logic [31:0] epc;
    logic [31:0] bad;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.exc_valid = 1'b0;
    bus.exc_flags = '0;
    bus.eret      = 1'b0;
    bus.exc_in_delay_slot = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h80001000, 1'b0, 7'h08, 32'h0,    1'b0, 32'h0,    1'b1, 5'd8,  32'h7000, 32'h80001000, 32'h0};
    vecs[1]  = '{1'b1, 32'h80002004, 1'b1, 7'h20, 32'h3,    1'b0, 32'h0,    1'b1, 5'd4,  32'h7100, 32'h80002000, 32'h3};
    vecs[2]  = '{1'b1, 32'h80004000, 1'b0, 7'h03, 32'h0,    1'b0, 32'h0,    1'b1, 5'd4,  32'h7100, 32'h80004000, 32'h80004000};
    vecs[3]  = '{1'b1, 32'h80005000, 1'b0, 7'h06, 32'h0,    1'b0, 32'h0,    1'b1, 5'd10, 32'h7000, 32'h80005000, 32'h0};
    vecs[4]  = '{1'b1, 32'h80006000, 1'b0, 7'h0C, 32'h0,    1'b0, 32'h0,    1'b1, 5'd12, 32'h7000, 32'h80006000, 32'h0};
    vecs[5]  = '{1'b1, 32'h80007000, 1'b0, 7'h10, 32'h0,    1'b0, 32'h0,    1'b1, 5'd9,  32'h7000, 32'h80007000, 32'h0};
    vecs[6]  = '{1'b1, 32'h80008000, 1'b0, 7'h40, 32'h1234, 1'b0, 32'h0,    1'b1, 5'd5,  32'h7100, 32'h80008000, 32'h1234};
    vecs[7]  = '{1'b0, 32'h80009000, 1'b0, 7'h10, 32'h0,    1'b0, 32'h0,    1'b0, 5'd0,  32'h0,    32'h0,        32'h0};
    vecs[8]  = '{1'b1, 32'h8000A000, 1'b0, 7'h08, 32'h0,    1'b1, 32'h0,    1'b1, 5'd8,  32'h7000, 32'h8000A000, 32'h0};
    vecs[9]  = '{1'b1, 32'h00000000, 1'b1, 7'h10, 32'h0,    1'b0, 32'h0,    1'b1, 5'd9,  32'h7000, 32'hFFFFFFFC, 32'h0};
    vecs[10] = '{1'b1, 32'h8000B000, 1'b0, 7'h08, 32'h0,    1'b0, 32'hFF01, 1'b1, 5'd8,  32'h7000, 32'h8000B000, 32'h0};

    idle_inputs();
    bus.exc_pc = '0; bus.exc_data_addr = '0; bus.hw_int = '0;
    bus.status_in = '0; bus.cause_in = '0; bus.epc_in = '0;

    repeat (3) tick();
    rst = 1'b0;
    chk("reset_we", bus.cp0_we, 32'h0);
    chk("reset_flush", {31'd0, bus.flush}, 32'h0);
    chk("reset_redir", {31'd0, bus.redirect_valid}, 32'h0);
    chk("reset_redir_pc", bus.redirect_pc, 32'h0);
    chk("reset_busy", {31'd0, bus.busy}, 32'h0);
    chk("reset_hw_int", {26'd0, bus.cp0_hw_int}, 32'h0);

    // synchronizer latency: rises before edge t, visible after edge t+1
    bus.hw_int = 6'h01;
    tick();
    chk("sync_t", {26'd0, bus.cp0_hw_int}, 32'h0);
    tick();
    chk("sync_t1", {26'd0, bus.cp0_hw_int}, 32'h1);

    // interrupt beats Ov in the same cycle
    bus.status_in = 32'h0000FF01;
    bus.exc_valid = 1'b1; bus.exc_flags = 7'h04; bus.exc_pc = 32'h80000100;
    tick();
    idle_inputs();
    chk("int_code", {27'd0, bus.cp0_exc_code}, 32'd0);
    chk("int_we", bus.cp0_we, 32'h7000);
    chk("int_epc", bus.cp0_epc, 32'h80000100);
    chk("int_ie", {31'd0, bus.cp0_ie}, 32'h1);
    chk("int_im", {24'd0, bus.cp0_int_enable}, 32'hFF);
    tick();
    chk("int_redir", {31'd0, bus.redirect_valid}, 32'h1);
    tick();
    chk("int_idle", {31'd0, bus.busy}, 32'h0);

    // EXL blocks the interrupt, then ERET returns to EPC
    bus.status_in = 32'h0000FF03;
    bus.exc_valid = 1'b1;
    tick();
    chk("exl_busy", {31'd0, bus.busy}, 32'h0);
    chk("exl_we", bus.cp0_we, 32'h0);
    bus.eret = 1'b1; bus.epc_in = 32'h80003000;
    tick();
    idle_inputs();
    chk("eret_we", bus.cp0_we, 32'h1000);
    chk("eret_exl", {31'd0, bus.cp0_exl}, 32'h0);
    chk("eret_ie", {31'd0, bus.cp0_ie}, 32'h1);
    chk("eret_redir", {31'd0, bus.redirect_valid}, 32'h1);
    chk("eret_pc", bus.redirect_pc, 32'h80003000);
    chk("eret_flush", {31'd0, bus.flush}, 32'h1);
    tick();
    chk("eret_idle", {31'd0, bus.busy}, 32'h0);
    chk("eret_done", {31'd0, bus.redirect_valid}, 32'h0);

    bus.hw_int = '0; bus.status_in = '0;
    repeat (3) tick();

    for (int i = 0; i < 11; i++) begin
      bus.exc_valid = vecs[i].valid; bus.exc_pc = vecs[i].pc;
      bus.exc_in_delay_slot = vecs[i].ds; bus.exc_flags = vecs[i].flags;
      bus.exc_data_addr = vecs[i].addr; bus.eret = vecs[i].er;
      bus.status_in = vecs[i].status;
      tick();
      idle_inputs();
      chk($sformatf("v%0d_we", i), bus.cp0_we, vecs[i].we);
      chk($sformatf("v%0d_busy", i), {31'd0, bus.busy}, {31'd0, vecs[i].take});
      if (vecs[i].take) begin
        chk($sformatf("v%0d_code", i), {27'd0, bus.cp0_exc_code}, {27'd0, vecs[i].code});
        chk($sformatf("v%0d_epc", i), bus.cp0_epc, vecs[i].epc);
        chk($sformatf("v%0d_bad", i), bus.cp0_badaddr, vecs[i].bad);
        chk($sformatf("v%0d_bd", i), {31'd0, bus.cp0_branch_delay}, {31'd0, vecs[i].ds});
        chk($sformatf("v%0d_exl", i), {31'd0, bus.cp0_exl}, 32'h1);
        chk($sformatf("v%0d_ie", i), {31'd0, bus.cp0_ie}, {31'd0, vecs[i].status[0]});
        chk($sformatf("v%0d_flush", i), {31'd0, bus.flush}, 32'h1);
        chk($sformatf("v%0d_redir_early", i), {31'd0, bus.redirect_valid}, 32'h0);
        tick();
        chk($sformatf("v%0d_redir", i), {31'd0, bus.redirect_valid}, 32'h1);
        chk($sformatf("v%0d_vec", i), bus.redirect_pc, 32'hBFC00380);
        chk($sformatf("v%0d_rflush", i), {31'd0, bus.flush}, 32'h1);
        chk($sformatf("v%0d_rwe", i), bus.cp0_we, 32'h0);
        tick();
        chk($sformatf("v%0d_end", i), {31'd0, bus.busy}, 32'h0);
      end
    end

    // reset during COMMIT: no REDIRECT pulse afterwards
    bus.status_in = '0;
    bus.exc_valid = 1'b1; bus.exc_flags = 7'h08; bus.exc_pc = 32'h80001000;
    tick();
    idle_inputs();
    chk("rc_commit", bus.cp0_we, 32'h7000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rc_we", bus.cp0_we, 32'h0);
    chk("rc_flush", {31'd0, bus.flush}, 32'h0);
    chk("rc_redir", {31'd0, bus.redirect_valid}, 32'h0);
    chk("rc_busy", {31'd0, bus.busy}, 32'h0);
    chk("rc_epc", bus.cp0_epc, 32'h0);
    tick();
    chk("rc_no_redir", {31'd0, bus.redirect_valid}, 32'h0);
    chk("rc_no_flush", {31'd0, bus.flush}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
